// File: rtl/alien_pkg.sv
// Shared formation geometry, sprite-type encoding and row-to-type mapping for the alien fetch path.
// Latency: n/a (constants and a pure function only).
// Backpressure: n/a.
package alien_pkg;

  localparam int COLS   = 11;  // formation columns
  localparam int ROWS   = 5;   // formation rows
  localparam int SPR_W  = 16;  // sprite width in pixels
  localparam int SPR_H  = 15;  // sprite height in pixels
  localparam int CELL_W = 24;  // horizontal cell pitch, >= SPR_W
  localparam int CELL_H = 20;  // vertical cell pitch, >= SPR_H

  // 3 sprite types x 2 walk frames x SPR_H rows x SPR_W pixels
  localparam int SPRITE_WORDS = 1440;

  typedef enum logic [1:0] {
    ALIEN_SQUID = 2'd0,
    ALIEN_CRAB  = 2'd1,
    ALIEN_OCTO  = 2'd2
  } alien_type_e;

  // Top row is squids, next two crabs, bottom two octopuses.
  function automatic alien_type_e row_to_type(input logic [2:0] row);
    if (row == 3'd0) begin
      return ALIEN_SQUID;
    end else if (row <= 3'd2) begin
      return ALIEN_CRAB;
    end else begin
      return ALIEN_OCTO;
    end
  endfunction

endpackage

// File: rtl/alien_anim_timer.sv
// Two-frame walk animation: counts frame_start pulses and toggles anim_frame every STEP_FRAMES pulses.
// Latency: anim_frame changes on the clock edge that samples the STEP_FRAMES-th frame_start.
// Backpressure: none; frame_start is consumed unconditionally.
// Ports: clk_i clock, rst_i async active-high reset, frame_start_i frame pulse, anim_frame_o current walk frame.
module alien_anim_timer #(
  parameter int STEP_FRAMES = 30
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic frame_start_i,
  output logic anim_frame_o
);

  localparam int CW = (STEP_FRAMES > 1) ? $clog2(STEP_FRAMES) : 1;

  logic [CW-1:0] cnt_q, cnt_d;
  logic          anim_q, anim_d;

  always_comb begin
    cnt_d  = cnt_q;
    anim_d = anim_q;
    if (frame_start_i) begin
      if (cnt_q == CW'(STEP_FRAMES - 1)) begin
        cnt_d  = '0;
        anim_d = ~anim_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q  <= '0;
      anim_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      anim_q <= anim_d;
    end
  end

  assign anim_frame_o = anim_q;

endmodule

// File: rtl/alien_sprite_fetch.sv
// Per-pixel alien sprite fetch: maps DrawX/DrawY to a formation cell, addresses sprite RAM, emits pixel_on/color_idx.
// Latency: DrawX/DrawY to pixel_on/color_idx/hit_* is 3 cycles; read_address is registered 1 cycle after the pixel.
// Backpressure: none; fully pipelined, one pixel per cycle, never stalls.
// Ports: Clk/Reset (async active-high); frame_start loads origin_x/origin_y/alive shadows; DrawX/DrawY pixel in;
//        read_address -> sprite RAM, ram_data <- RAM (1-cycle latency, [2:0] palette, 0 = transparent);
//        pixel_on/color_idx/hit_col/hit_row to colour mapper.
// Optional: define ALIEN_BBOX_EN to force the sprite-box outline of every live cell to palette index 7.
module alien_sprite_fetch
  import alien_pkg::*;
#(
  parameter int STEP_FRAMES = 30
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 frame_start,
  input  logic [9:0]           DrawX,
  input  logic [9:0]           DrawY,
  input  logic [9:0]           origin_x,
  input  logic [9:0]           origin_y,
  input  logic [COLS*ROWS-1:0] alive,
  output logic [18:0]          read_address,
  input  logic [4:0]           ram_data,
  output logic                 pixel_on,
  output logic [2:0]           color_idx,
  output logic [3:0]           hit_col,
  output logic [2:0]           hit_row
);

  localparam int SXW = $clog2(SPR_W);
  localparam int SYW = $clog2(SPR_H);
  localparam int CIW = $clog2(COLS * ROWS);

  logic anim_frame;

  alien_anim_timer #(
    .STEP_FRAMES(STEP_FRAMES)
  ) u_anim (
    .clk_i        (Clk),
    .rst_i        (Reset),
    .frame_start_i(frame_start),
    .anim_frame_o (anim_frame)
  );

  // Frame-synchronous shadows; all pixel math reads these so the formation never tears mid-frame.
  logic [9:0]           sh_origin_x_q, sh_origin_x_d;
  logic [9:0]           sh_origin_y_q, sh_origin_y_d;
  logic [COLS*ROWS-1:0] sh_alive_q,    sh_alive_d;

  // Pipeline registers.
  logic [18:0] read_address_q, read_address_d;
  logic        valid1_q, valid1_d, valid2_q;
  logic [3:0]  col1_q, col1_d, col2_q;
  logic [2:0]  row1_q, row1_d, row2_q;
  logic        pixel_on_q, pixel_on_d;
  logic [2:0]  color_idx_q, color_idx_d;
  logic [3:0]  hit_col_q, hit_col_d;
  logic [2:0]  hit_row_q, hit_row_d;

  // Stage-1 combinational terms.
  logic signed [10:0] rx, ry;
  logic [9:0]         col_full, row_full, sx, sy;
  logic               cell_ok, in_spr;
  logic [CIW-1:0]     cell_idx;
  alien_type_e        spr_type;
  logic [10:0]        addr;

  // Zero-extend before subtracting so an origin to the right of/below the pixel goes negative instead of wrapping.
  assign rx = $signed({1'b0, DrawX}) - $signed({1'b0, sh_origin_x_q});
  assign ry = $signed({1'b0, DrawY}) - $signed({1'b0, sh_origin_y_q});

  always_comb begin
    col_full = rx[9:0] / 10'(CELL_W);
    row_full = ry[9:0] / 10'(CELL_H);
    sx       = rx[9:0] - 10'(col_full * 10'(CELL_W));
    sy       = ry[9:0] - 10'(row_full * 10'(CELL_H));
    cell_ok  = !rx[10] && !ry[10] && (col_full < 10'(COLS)) && (row_full < 10'(ROWS));
    // Only meaningful when cell_ok; otherwise it may point past the bitmap and is masked below.
    cell_idx = CIW'(row_full[2:0]) * CIW'(COLS) + CIW'(col_full[3:0]);
    in_spr   = cell_ok && (sx < 10'(SPR_W)) && (sy < 10'(SPR_H)) && sh_alive_q[cell_idx];
    spr_type = row_to_type(row_full[2:0]);
    // {type, frame} equals type*2 + anim_frame.
    addr     = (11'({spr_type, anim_frame}) * 11'(SPR_H) + 11'(sy[SYW-1:0])) * 11'(SPR_W)
             + 11'(sx[SXW-1:0]);
  end

  always_comb begin
    sh_origin_x_d = sh_origin_x_q;
    sh_origin_y_d = sh_origin_y_q;
    sh_alive_d    = sh_alive_q;
    if (frame_start) begin
      sh_origin_x_d = origin_x;
      sh_origin_y_d = origin_y;
      sh_alive_d    = alive;
    end

    read_address_d = in_spr ? 19'(addr) : '0;
    valid1_d       = in_spr;
    col1_d         = in_spr ? col_full[3:0] : '0;
    row1_d         = in_spr ? row_full[2:0] : '0;
  end

`ifdef ALIEN_BBOX_EN
  logic border1_q, border1_d, border2_q;
  always_comb begin
    border1_d = in_spr && ((sx == 10'd0) || (sx == 10'(SPR_W - 1)) ||
                           (sy == 10'd0) || (sy == 10'(SPR_H - 1)));
  end
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      border1_q <= 1'b0;
      border2_q <= 1'b0;
    end else begin
      border1_q <= border1_d;
      border2_q <= border1_q;
    end
  end
`endif

  // Stage 3: ram_data now corresponds to the address issued two cycles ago; bits [4:3] carry nothing for us.
  logic       unused_ram_hi;
  logic       pix_on;
  logic [2:0] pix_color;
  assign unused_ram_hi = ^ram_data[4:3];

  always_comb begin
`ifdef ALIEN_BBOX_EN
    pix_on    = valid2_q && ((ram_data[2:0] != 3'd0) || border2_q);
    pix_color = border2_q ? 3'd7 : ram_data[2:0];
`else
    pix_on    = valid2_q && (ram_data[2:0] != 3'd0);
    pix_color = ram_data[2:0];
`endif
    pixel_on_d  = pix_on;
    color_idx_d = pix_on ? pix_color : '0;
    hit_col_d   = pix_on ? col2_q : '0;
    hit_row_d   = pix_on ? row2_q : '0;
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      sh_origin_x_q  <= '0;
      sh_origin_y_q  <= '0;
      sh_alive_q     <= '0;
      read_address_q <= '0;
      valid1_q       <= 1'b0;
      col1_q         <= '0;
      row1_q         <= '0;
      valid2_q       <= 1'b0;
      col2_q         <= '0;
      row2_q         <= '0;
      pixel_on_q     <= 1'b0;
      color_idx_q    <= '0;
      hit_col_q      <= '0;
      hit_row_q      <= '0;
    end else begin
      sh_origin_x_q  <= sh_origin_x_d;
      sh_origin_y_q  <= sh_origin_y_d;
      sh_alive_q     <= sh_alive_d;
      read_address_q <= read_address_d;
      valid1_q       <= valid1_d;
      col1_q         <= col1_d;
      row1_q         <= row1_d;
      valid2_q       <= valid1_q;
      col2_q         <= col1_q;
      row2_q         <= row1_q;
      pixel_on_q     <= pixel_on_d;
      color_idx_q    <= color_idx_d;
      hit_col_q      <= hit_col_d;
      hit_row_q      <= hit_row_d;
    end
  end

  assign read_address = read_address_q;
  assign pixel_on     = pixel_on_q;
  assign color_idx    = color_idx_q;
  assign hit_col      = hit_col_q;
  assign hit_row      = hit_row_q;

endmodule

// File: tb/tb_alien_sprite_fetch.sv
// Self-checking bench for alien_sprite_fetch: scoreboard of expected address/pixel results from a reference model.
// Latency: expects read_address 1 cycle and pixel outputs 3 cycles after each driven pixel.
// Backpressure: none; one pixel driven per cycle.
module tb_alien_sprite_fetch;
  import alien_pkg::*;

  localparam int STEP = 30;
`ifdef ALIEN_BBOX_EN
  localparam bit BBOX = 1'b1;
`else
  localparam bit BBOX = 1'b0;
`endif

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        frame_start = 1'b0;
  logic [9:0]  DrawX = '0, DrawY = '0, origin_x = '0, origin_y = '0;
  logic [54:0] alive = '0;
  logic [18:0] read_address;
  logic [4:0]  ram_data = '0;
  logic        pixel_on;
  logic [2:0]  color_idx;
  logic [3:0]  hit_col;
  logic [2:0]  hit_row;

  alien_sprite_fetch #(.STEP_FRAMES(STEP)) dut (
    .Clk(Clk), .Reset(Reset), .frame_start(frame_start),
    .DrawX(DrawX), .DrawY(DrawY), .origin_x(origin_x), .origin_y(origin_y),
    .alive(alive), .read_address(read_address), .ram_data(ram_data),
    .pixel_on(pixel_on), .color_idx(color_idx), .hit_col(hit_col), .hit_row(hit_row)
  );

  always #5 Clk = ~Clk;

  // Sprite RAM stand-in with one cycle of read latency; upper data bits are random junk.
  logic [4:0] mem [0:SPRITE_WORDS-1];
  always @(posedge Clk)
    ram_data <= (int'(read_address) < SPRITE_WORDS) ? mem[read_address[10:0]] : 5'h1F;

  int cyc = 0;
  always @(posedge Clk) cyc++;

  typedef struct {
    int due;
    bit ins;
    int addr;
    int col;
    int row;
    bit border;
  } exp_t;

  exp_t aq[$];
  exp_t pq[$];

  // Reference-model state: what the formation looked like at the last frame_start.
  int          sh_ox = 0, sh_oy = 0, pulses = 0;
  logic [54:0] sh_alive = '0;

  int total = 0, bad = 0;
  bit end_req = 0, end_done = 0;

  task automatic model(input int x, input int y, output exp_t e);
    int rx, ry, sx, sy, typ, anim;
    e = '{default: 0};
    rx = x - sh_ox;
    ry = y - sh_oy;
    if (rx < 0 || ry < 0) return;
    e.col = rx / CELL_W;
    e.row = ry / CELL_H;
    sx = rx % CELL_W;
    sy = ry % CELL_H;
    if (e.col >= COLS || e.row >= ROWS || sx >= SPR_W || sy >= SPR_H) return;
    if (!sh_alive[e.row * COLS + e.col]) return;
    typ  = (e.row == 0) ? 0 : (e.row < 3) ? 1 : 2;
    anim = (pulses / STEP) % 2;
    e.ins    = 1'b1;
    e.addr   = ((typ * 2 + anim) * SPR_H + sy) * SPR_W + sx;
    e.border = (sx == 0) || (sx == SPR_W - 1) || (sy == 0) || (sy == SPR_H - 1);
  endtask

  task automatic drive(input int x, input int y, input bit fs);
    exp_t e;
    DrawX = 10'(x);
    DrawY = 10'(y);
    frame_start = fs;
    model(x, y, e);
    e.due = cyc + 1;
    aq.push_back(e);
    e.due = cyc + 3;
    pq.push_back(e);
    if (fs) begin
      sh_ox = int'(origin_x);
      sh_oy = int'(origin_y);
      sh_alive = alive;
      pulses++;
    end
    @(posedge Clk);
    #1;
    frame_start = 1'b0;
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    frame_start = 1'b0;
    aq.delete();
    pq.delete();
    sh_ox = 0;
    sh_oy = 0;
    sh_alive = '0;
    pulses = 0;
    repeat (2) @(posedge Clk);
    #1;
    Reset = 1'b0;
  endtask

  // Monitor: all checking happens here, on the falling edge.
  always @(negedge Clk) begin : monitor
    exp_t ea;
    int   want_addr, ramv, want_col;
    bit   bx, want_on;
    if (Reset) begin
      total++;
      if (read_address != '0 || pixel_on || color_idx != '0 || hit_col != '0 || hit_row != '0) begin
        bad++;
        $display("FAIL reset_zero t=%0t addr=%0d on=%0b color=%0d col=%0d row=%0d required all 0",
                 $time, read_address, pixel_on, color_idx, hit_col, hit_row);
      end
    end else begin
      while (aq.size() > 0 && aq[0].due <= cyc) begin
        ea = aq.pop_front();
        want_addr = ea.ins ? ea.addr : 0;
        total++;
        if (ea.due != cyc || int'(read_address) != want_addr) begin
          bad++;
          $display("FAIL read_address cyc=%0d got=%0d required=%0d", cyc, read_address, want_addr);
        end
      end
      while (pq.size() > 0 && pq[0].due <= cyc) begin
        ea = pq.pop_front();
        ramv     = ea.ins ? int'(mem[ea.addr][2:0]) : 0;
        bx       = BBOX && ea.ins && ea.border;
        want_on  = ea.ins && (ramv != 0 || bx);
        want_col = bx ? 7 : (want_on ? ramv : 0);
        total++;
        if (ea.due != cyc || pixel_on != want_on || int'(color_idx) != want_col) begin
          bad++;
          $display("FAIL pixel cyc=%0d on=%0b color=%0d required on=%0b color=%0d",
                   cyc, pixel_on, color_idx, want_on, want_col);
        end
        total++;
        if (int'(hit_col) != (want_on ? ea.col : 0) || int'(hit_row) != (want_on ? ea.row : 0)) begin
          bad++;
          $display("FAIL hit cyc=%0d col=%0d row=%0d required col=%0d row=%0d",
                   cyc, hit_col, hit_row, want_on ? ea.col : 0, want_on ? ea.row : 0);
        end
      end
      if (end_req && !end_done) begin
        total++;
        if (aq.size() + pq.size() != 0) begin
          bad++;
          $display("FAIL drain leftover=%0d required=0", aq.size() + pq.size());
        end
        end_done = 1'b1;
      end
    end
  end

  initial begin
    logic [63:0] r64;
    int x, y;
    for (int i = 0; i < SPRITE_WORDS; i++)
      mem[i] = ($urandom_range(0, 2) == 0) ? 5'(8 * $urandom_range(0, 3)) : 5'($urandom_range(0, 31));
    mem[0] = 5'd5;

    // Reset held across a few edges; nothing drawn before the first frame_start.
    repeat (3) @(posedge Clk);
    #1;
    Reset = 1'b0;
    origin_x = 10'd100;
    origin_y = 10'd50;
    alive = '1;
    drive(100, 50, 1'b0);
    drive(0, 0, 1'b1);

    // Directed points: cell origin, cell (1,1), gap, left/top of formation.
    drive(100, 50, 1'b0);
    drive(124, 70, 1'b0);
    drive(116, 50, 1'b0);
    drive(99, 50, 1'b0);
    drive(100, 49, 1'b0);
    drive(115, 64, 1'b0);
    drive(363, 144, 1'b0);

    // Dead cell 12 reads address 0 (mem[0] is opaque) and must stay dark.
    alive[12] = 1'b0;
    drive(124, 70, 1'b1);
    drive(124, 70, 1'b0);
    drive(130, 75, 1'b0);

    // frame_start with a visible pixel: that pixel uses the old shadows.
    alive = '1;
    origin_x = 10'd300;
    drive(124, 70, 1'b1);
    drive(124, 70, 1'b0);
    origin_x = 10'd100;

    // Walk animation toggle after 30 and 60 pulses.
    while (pulses < 30) drive(0, 0, 1'b1);
    drive(100, 50, 1'b0);
    drive(124, 70, 1'b0);
    while (pulses < 60) drive(0, 0, 1'b1);
    drive(100, 50, 1'b0);

    // Formation hanging off the bottom-right of the screen.
    origin_x = 10'd630;
    origin_y = 10'd470;
    drive(0, 0, 1'b1);
    for (int i = 0; i < 40; i++)
      drive(630 + int'($urandom_range(0, 40)), 470 + int'($urandom_range(0, 40)), 1'b0);
    drive(5, 5, 1'b0);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 99) < 2) begin
        origin_x = 10'($urandom_range(0, 700));
        origin_y = 10'($urandom_range(0, 500));
        r64 = {$urandom, $urandom};
        alive = r64[54:0];
      end
      if ($urandom_range(0, 7) == 0) begin
        x = int'($urandom_range(0, 1023));
        y = int'($urandom_range(0, 1023));
      end else begin
        x = sh_ox + int'($urandom_range(0, 290)) - 10;
        y = sh_oy + int'($urandom_range(0, 115)) - 10;
      end
      if (x < 0) x = 0;
      if (x > 1023) x = 1023;
      if (y < 0) y = 0;
      if (y > 1023) y = 1023;
      drive(x, y, $urandom_range(0, 39) == 0);
    end

    // Reset in the middle of an opaque stream, then dark until the next frame_start.
    origin_x = 10'd100;
    origin_y = 10'd50;
    alive = '1;
    drive(0, 0, 1'b1);
    for (int i = 0; i < 6; i++) drive(100 + i, 50, 1'b0);
    do_reset();
    for (int i = 0; i < 16; i++) drive(100 + i, 50 + i, 1'b0);
    drive(0, 0, 1'b1);
    for (int i = 0; i < 16; i++) drive(100 + i, 50, 1'b0);

    repeat (4) @(posedge Clk);
    #1;
    end_req = 1'b1;
    repeat (3) @(posedge Clk);
    if (!end_done) $display("FAIL drain_check not reached");
    $display("test done: total=%0d bad=%0d", total, bad + (end_done ? 0 : 1));
    $finish;
  end

endmodule
